// File: rtl/shift_register_arbiter.sv
// Round-robin arbiter feeding one shared fixed-latency delay pipeline.
// Each word carries its requester index; a downstream stall freezes every stage.
module shift_register_arbiter #(
  parameter int width      = 16,
  parameter int depth      = 2,
  parameter int requesters = 4,
  parameter int tag_width  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [requesters-1:0]        req_valid,
  input  logic [requesters*width-1:0]  req_data,
  output logic [requesters-1:0]        req_ready,
  output logic                         out_valid,
  output logic [width-1:0]             out_data,
  output logic [tag_width-1:0]         out_tag,
  input  logic                         out_ready
);

  // Handshake: a word transfers on a rising edge where valid and ready are both
  // high; valid never waits on ready, and a valid word holds until it transfers.
  logic                 stage_valid [depth];
  logic [tag_width-1:0] stage_tag   [depth];
  logic [width-1:0]     stage_data  [depth];

  logic [tag_width-1:0] ptr;
  logic                 advance;
  logic                 grant_any;
  logic                 accept;
  logic [tag_width-1:0] grant_idx;

  assign advance = out_ready | ~stage_valid[depth-1];
  assign accept  = grant_any & advance & ~reset;

  // Walk from the farthest offset down so the first valid requester at or
  // after ptr is the one left standing.
  always_comb begin
    int k;
    k         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int j = requesters - 1; j >= 0; j--) begin
      k = (int'(ptr) + j) % requesters;
      if (req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = k[tag_width-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < depth; k++) begin
        stage_valid[k] <= 1'b0;
        stage_tag[k]   <= '0;
        stage_data[k]  <= '0;
      end
      ptr <= '0;
    end else if (advance) begin
      stage_valid[0] <= accept;
      stage_tag[0]   <= accept ? grant_idx : '0;
      stage_data[0]  <= accept ? req_data[int'(grant_idx)*width +: width] : '0;
      for (int k = 1; k < depth; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_tag[k]   <= stage_tag[k-1];
        stage_data[k]  <= stage_data[k-1];
      end
      if (accept) begin
        if (grant_idx == tag_width'(requesters - 1)) ptr <= '0;
        else                                         ptr <= grant_idx + 1'b1;
      end
    end
  end

  assign out_valid = stage_valid[depth-1];
  assign out_tag   = stage_tag[depth-1];
  assign out_data  = stage_data[depth-1];

endmodule
